// File: rtl/gpio_flicker_endpoint.sv
// rtl/gpio_flicker_endpoint.sv - toggle-flag (flicker) byte endpoint between host registers and a core byte stream
//
// Purpose:
//   Replaces software GPIO polling of the host<->PULPino flicker protocol. Lives entirely in the
//   pulpino clock domain; the two host flicker inputs are synchronized here.
//   RX path: host sets ext_data_i and toggles ext_write_flicker_i; the byte is queued in a small
//   FIFO and pulpino_read_flicker_o toggles as the acknowledge.
//   TX path: a byte accepted on tx_data_i is driven on pulpino_data_o, pulpino_write_flicker_o
//   toggles one cycle later, and the block waits for the host to toggle ext_read_flicker_i.
//
// Configuration:
//   FLICKER_TIMEOUT_EN  when defined, WAIT_ACK gives up after pTIMEOUT_CYCLES and flags tx_timeout_o.
//
// Parameters:
//   pSYNC_STAGES     flops per flicker synchronizer (>= 2)
//   pRX_DEPTH        RX FIFO entries (power of 2, >= 2)
//   pTIMEOUT_CYCLES  TX acknowledge timeout in clk cycles (timeout build only)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ext_data_i                 host->target byte
//   ext_write_flicker_i        host toggle: new byte on ext_data_i
//   ext_read_flicker_i         host toggle: pulpino_data_o consumed
//   pulpino_data_o             target->host byte
//   pulpino_write_flicker_o    toggles when pulpino_data_o carries a new byte
//   pulpino_read_flicker_o     toggles when a host byte has been accepted
//   rx_data_o/valid_o/ready_i  RX FIFO head, pop on valid & ready
//   tx_data_i/valid_i/ready_o  TX byte request, accepted on valid & ready
//   rx_overflow_o              sticky: host wrote again while a byte was still unacknowledged
//   tx_timeout_o               sticky: TX acknowledge timed out (always 0 without the macro)
//   clear_err_i                clears the sticky error flags

module gpio_flicker_endpoint #(
    parameter int pSYNC_STAGES    = 2,
    parameter int pRX_DEPTH       = 4,
    parameter int pTIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ext_data_i,
    input  logic       ext_write_flicker_i,
    input  logic       ext_read_flicker_i,
    output logic [7:0] pulpino_data_o,
    output logic       pulpino_write_flicker_o,
    output logic       pulpino_read_flicker_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       rx_overflow_o,
    output logic       tx_timeout_o,
    input  logic       clear_err_i
);

    localparam int PW          = $clog2(pRX_DEPTH);
    localparam int CW          = PW + 1;
    localparam int MASK_CYCLES = pSYNC_STAGES + 1;
    localparam int MW          = $clog2(MASK_CYCLES + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(pRX_DEPTH);
    localparam logic [MW-1:0] MASK_END = MW'(MASK_CYCLES);

    // ------------------------------------------------------------------
    // Flicker synchronizers and toggle detection
    // ------------------------------------------------------------------
    logic [pSYNC_STAGES-1:0] wr_sync_q;
    logic [pSYNC_STAGES-1:0] rd_sync_q;
    logic                    wr_last_q;
    logic                    rd_last_q;
    logic [MW-1:0]           mask_cnt_q;
    logic                    det_en;
    logic                    wr_synced;
    logic                    rd_synced;
    logic                    wr_toggle;
    logic                    rd_toggle;

    assign wr_synced = wr_sync_q[pSYNC_STAGES-1];
    assign rd_synced = rd_sync_q[pSYNC_STAGES-1];

    // Right after reset the chains fill with whatever level the host is holding;
    // until that level has reached *_last_q, a difference is not a real toggle.
    assign det_en    = (mask_cnt_q == MASK_END);
    assign wr_toggle = det_en & (wr_synced ^ wr_last_q);
    assign rd_toggle = det_en & (rd_synced ^ rd_last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync_q  <= '0;
            rd_sync_q  <= '0;
            wr_last_q  <= 1'b0;
            rd_last_q  <= 1'b0;
            mask_cnt_q <= '0;
        end else begin
            wr_sync_q <= {wr_sync_q[pSYNC_STAGES-2:0], ext_write_flicker_i};
            rd_sync_q <= {rd_sync_q[pSYNC_STAGES-2:0], ext_read_flicker_i};
            wr_last_q <= wr_synced;
            rd_last_q <= rd_synced;
            if (!det_en) begin
                mask_cnt_q <= mask_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX capture stage: the byte is sampled in the cycle the toggle is seen
    // and handed to the FIFO logic on the following edge.
    // ------------------------------------------------------------------
    logic       wr_evt_q;
    logic [7:0] wr_byte_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_evt_q  <= 1'b0;
            wr_byte_q <= '0;
        end else begin
            wr_evt_q <= wr_toggle;
            if (wr_toggle) begin
                wr_byte_q <= ext_data_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO with one-entry pending register
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [pRX_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full;
    logic          pop;
    logic          pend_valid_q;
    logic [7:0]    pend_data_q;
    logic          pend_push;
    logic          evt_push;
    logic          evt_hold;
    logic          evt_drop;
    logic          push;
    logic [7:0]    push_data;
    logic          rd_flicker_q;
    logic          ovf_q;

    assign full       = (count_q == CNT_FULL);
    assign rx_valid_o = (count_q != '0);
    assign rx_data_o  = mem_q[rd_ptr_q];
    assign pop        = rx_valid_o & rx_ready_i;

    // A held byte only moves once the FIFO has visibly drained by one entry,
    // so it lands (and is acknowledged) the cycle after the freeing pop.
    assign pend_push = pend_valid_q & ~full;
    assign evt_push  = wr_evt_q & ~pend_valid_q & (~full | pop);
    assign evt_hold  = wr_evt_q & ~pend_valid_q & full & ~pop;
    // The host may not write again before it sees the acknowledge; a byte
    // arriving while one is still held is dropped.
    assign evt_drop  = wr_evt_q & pend_valid_q;
    assign push      = pend_push | evt_push;
    assign push_data = pend_valid_q ? pend_data_q : wr_byte_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < pRX_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            rd_flicker_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
                rd_flicker_q    <= ~rd_flicker_q;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (evt_hold) begin
                pend_valid_q <= 1'b1;
                pend_data_q  <= wr_byte_q;
            end else if (pend_push) begin
                pend_valid_q <= 1'b0;
            end

            // A new error in the same cycle as a clear keeps the flag set.
            if (evt_drop) begin
                ovf_q <= 1'b1;
            end else if (clear_err_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign pulpino_read_flicker_o = rd_flicker_q;
    assign rx_overflow_o          = ovf_q;

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } tx_state_t;

    tx_state_t  state_q;
    tx_state_t  state_d;
    logic       tx_accept;
    logic       tx_toggle;
    logic       timeout_hit;
    logic       timeout_set;
    logic       tx_active;
    logic [7:0] tx_data_q;
    logic       wr_flicker_q;

    // Nothing is accepted while reset is held; the first clock after release
    // moves mask_cnt_q off zero and opens the TX side.
    assign tx_active  = (mask_cnt_q != '0);
    assign tx_ready_o = (state_q == ST_IDLE) & tx_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_accept   = 1'b0;
        tx_toggle   = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid_i && tx_active) begin
                    tx_accept = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Data has been on the pins for a full cycle before the flicker moves.
                tx_toggle = 1'b1;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (rd_toggle) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q    <= '0;
            wr_flicker_q <= 1'b0;
        end else begin
            if (tx_accept) begin
                tx_data_q <= tx_data_i;
            end
            if (tx_toggle) begin
                wr_flicker_q <= ~wr_flicker_q;
            end
        end
    end

    assign pulpino_data_o          = tx_data_q;
    assign pulpino_write_flicker_o = wr_flicker_q;

    // ------------------------------------------------------------------
    // Optional TX acknowledge timeout
    // ------------------------------------------------------------------
`ifdef FLICKER_TIMEOUT_EN
    localparam int TW = ($clog2(pTIMEOUT_CYCLES + 1) > 16) ? $clog2(pTIMEOUT_CYCLES + 1) : 16;
    localparam logic [TW-1:0] TO_LAST = TW'(pTIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q;
    logic          to_flag_q;

    // to_cnt_q counts completed WAIT_ACK cycles; the last allowed one exits.
    assign timeout_hit = (state_q == ST_WAIT_ACK) && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            if (state_q == ST_SETUP) begin
                to_cnt_q <= '0;
            end else if (state_q == ST_WAIT_ACK) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (timeout_set) begin
                to_flag_q <= 1'b1;
            end else if (clear_err_i) begin
                to_flag_q <= 1'b0;
            end
        end
    end

    assign tx_timeout_o = to_flag_q;
`else
    // Without the timeout build WAIT_ACK waits indefinitely; the parameter is inert.
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign tx_timeout_o       = 1'b0;
    assign unused_timeout_cfg = ^pTIMEOUT_CYCLES ^ timeout_set;
`endif

endmodule

// File: tb/tb_gpio_flicker_endpoint.sv
// tb/tb_gpio_flicker_endpoint.sv - directed self-checking bench for gpio_flicker_endpoint

module tb_gpio_flicker_endpoint;

    logic       clk;
    logic       rst_n;
    logic [7:0] ext_data_i;
    logic       ext_write_flicker_i;
    logic       ext_read_flicker_i;
    logic [7:0] pulpino_data_o;
    logic       pulpino_write_flicker_o;
    logic       pulpino_read_flicker_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       rx_overflow_o;
    logic       tx_timeout_o;
    logic       clear_err_i;

    int n_cmp;
    int n_bad;

    gpio_flicker_endpoint #(
        .pSYNC_STAGES   (2),
        .pRX_DEPTH      (4),
        .pTIMEOUT_CYCLES(16)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ext_data_i             (ext_data_i),
        .ext_write_flicker_i    (ext_write_flicker_i),
        .ext_read_flicker_i     (ext_read_flicker_i),
        .pulpino_data_o         (pulpino_data_o),
        .pulpino_write_flicker_o(pulpino_write_flicker_o),
        .pulpino_read_flicker_o (pulpino_read_flicker_o),
        .rx_data_o              (rx_data_o),
        .rx_valid_o             (rx_valid_o),
        .rx_ready_i             (rx_ready_i),
        .tx_data_i              (tx_data_i),
        .tx_valid_i             (tx_valid_i),
        .tx_ready_o             (tx_ready_o),
        .rx_overflow_o          (rx_overflow_o),
        .tx_timeout_o           (tx_timeout_o),
        .clear_err_i            (clear_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       exp_rflk;
        logic       exp_ovf;
    } rx_vec_t;

    rx_vec_t    rx_tbl [6];
    logic [7:0] pop_tbl [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [7:0] b);
        ext_data_i          = b;
        ext_write_flicker_i = ~ext_write_flicker_i;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " pulpino_data_o"}, {24'd0, pulpino_data_o}, 32'd0);
        chk({tag, " write_flicker"}, {31'd0, pulpino_write_flicker_o}, 32'd0);
        chk({tag, " read_flicker"}, {31'd0, pulpino_read_flicker_o}, 32'd0);
        chk({tag, " rx_data_o"}, {24'd0, rx_data_o}, 32'd0);
        chk({tag, " rx_valid_o"}, {31'd0, rx_valid_o}, 32'd0);
        chk({tag, " tx_ready_o"}, {31'd0, tx_ready_o}, 32'd0);
        chk({tag, " rx_overflow_o"}, {31'd0, rx_overflow_o}, 32'd0);
        chk({tag, " tx_timeout_o"}, {31'd0, tx_timeout_o}, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // After A5 the read flicker sits at 1; each accepted byte flips it.
        rx_tbl[0] = '{8'h01, 1'b0, 1'b0};
        rx_tbl[1] = '{8'h02, 1'b1, 1'b0};
        rx_tbl[2] = '{8'h03, 1'b0, 1'b0};
        rx_tbl[3] = '{8'h04, 1'b1, 1'b0};
        rx_tbl[4] = '{8'h05, 1'b1, 1'b0};
        rx_tbl[5] = '{8'hFF, 1'b1, 1'b1};
        pop_tbl[0] = 8'h02;
        pop_tbl[1] = 8'h03;
        pop_tbl[2] = 8'h04;
        pop_tbl[3] = 8'h05;

        // Flicker inputs held high through reset release.
        rst_n               = 1'b0;
        ext_data_i          = 8'h00;
        ext_write_flicker_i = 1'b1;
        ext_read_flicker_i  = 1'b1;
        rx_ready_i          = 1'b0;
        tx_data_i           = 8'h00;
        tx_valid_i          = 1'b0;
        clear_err_i         = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");

        rst_n = 1'b1;
        repeat (8) tick();
        chk("startup no rx event", {31'd0, rx_valid_o}, 32'd0);
        chk("startup no ack", {31'd0, pulpino_read_flicker_o}, 32'd0);
        chk("startup tx_ready", {31'd0, tx_ready_o}, 32'd1);

        // Single byte: valid appears exactly 4 cycles after the toggle.
        host_write(8'hA5);
        repeat (3) tick();
        chk("A5 valid not early", {31'd0, rx_valid_o}, 32'd0);
        tick();
        chk("A5 valid at 4", {31'd0, rx_valid_o}, 32'd1);
        chk("A5 data", {24'd0, rx_data_o}, 32'hA5);
        chk("A5 ack", {31'd0, pulpino_read_flicker_o}, 32'd1);
        repeat (4) tick();
        chk("A5 single ack", {31'd0, pulpino_read_flicker_o}, 32'd1);
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        chk("A5 popped", {31'd0, rx_valid_o}, 32'd0);

        // Fill FIFO, hold fifth byte, then overflow with FF.
        for (int i = 0; i < 6; i++) begin
            host_write(rx_tbl[i].data);
            repeat (6) tick();
            chk($sformatf("fill[%0d] ack", i), {31'd0, pulpino_read_flicker_o}, {31'd0, rx_tbl[i].exp_rflk});
            chk($sformatf("fill[%0d] ovf", i), {31'd0, rx_overflow_o}, {31'd0, rx_tbl[i].exp_ovf});
        end

        // One pop releases the held byte on the following cycle.
        chk("head 01", {24'd0, rx_data_o}, 32'h01);
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        chk("pending not yet acked", {31'd0, pulpino_read_flicker_o}, 32'd1);
        tick();
        chk("pending acked", {31'd0, pulpino_read_flicker_o}, 32'd0);

        clear_err_i = 1'b1;
        tick();
        clear_err_i = 1'b0;
        chk("ovf cleared", {31'd0, rx_overflow_o}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pop[%0d] valid", i), {31'd0, rx_valid_o}, 32'd1);
            chk($sformatf("pop[%0d] data", i), {24'd0, rx_data_o}, {24'd0, pop_tbl[i]});
            rx_ready_i = 1'b1;
            tick();
            rx_ready_i = 1'b0;
        end
        chk("FF never queued", {31'd0, rx_valid_o}, 32'd0);

        // TX handshake.
        tx_data_i  = 8'h3C;
        tx_valid_i = 1'b1;
        chk("tx idle ready", {31'd0, tx_ready_o}, 32'd1);
        tick();
        tx_valid_i = 1'b0;
        chk("tx data latched", {24'd0, pulpino_data_o}, 32'h3C);
        chk("tx flicker setup", {31'd0, pulpino_write_flicker_o}, 32'd0);
        chk("tx busy", {31'd0, tx_ready_o}, 32'd0);
        tick();
        chk("tx flicker toggled", {31'd0, pulpino_write_flicker_o}, 32'd1);
        repeat (5) tick();
        chk("tx wait ack", {31'd0, tx_ready_o}, 32'd0);
        ext_read_flicker_i = ~ext_read_flicker_i;
        repeat (2) tick();
        chk("tx ack not early", {31'd0, tx_ready_o}, 32'd0);
        tick();
        chk("tx ready after ack+3", {31'd0, tx_ready_o}, 32'd1);
        chk("tx data held", {24'd0, pulpino_data_o}, 32'h3C);
        chk("no timeout", {31'd0, tx_timeout_o}, 32'd0);

        // Read toggle while IDLE is ignored.
        ext_read_flicker_i = ~ext_read_flicker_i;
        repeat (6) tick();
        chk("stray ack ready", {31'd0, tx_ready_o}, 32'd1);
        chk("stray ack flicker", {31'd0, pulpino_write_flicker_o}, 32'd1);

        tx_data_i  = 8'h81;
        tx_valid_i = 1'b1;
        tick();
        tx_valid_i = 1'b0;
        tick();
        chk("tx2 data", {24'd0, pulpino_data_o}, 32'h81);
        chk("tx2 flicker", {31'd0, pulpino_write_flicker_o}, 32'd0);
`ifdef FLICKER_TIMEOUT_EN
        repeat (15) tick();
        chk("timeout not early", {31'd0, tx_ready_o}, 32'd0);
        tick();
        chk("timeout idle", {31'd0, tx_ready_o}, 32'd1);
        chk("timeout flag", {31'd0, tx_timeout_o}, 32'd1);
        chk("timeout flicker kept", {31'd0, pulpino_write_flicker_o}, 32'd0);
        clear_err_i = 1'b1;
        tick();
        clear_err_i = 1'b0;
        chk("timeout cleared", {31'd0, tx_timeout_o}, 32'd0);
`else
        repeat (40) tick();
        chk("wait forever", {31'd0, tx_ready_o}, 32'd0);
        chk("timeout tied 0", {31'd0, tx_timeout_o}, 32'd0);
        ext_read_flicker_i = ~ext_read_flicker_i;
        repeat (3) tick();
        chk("tx2 acked", {31'd0, tx_ready_o}, 32'd1);
`endif

        // Reset in the middle of a transfer with a byte queued.
        host_write(8'h77);
        repeat (6) tick();
        chk("pre-reset rx queued", {31'd0, rx_valid_o}, 32'd1);
        tx_data_i  = 8'h5A;
        tx_valid_i = 1'b1;
        tick();
        tx_valid_i = 1'b0;
        tick();
        chk("pre-reset tx busy", {31'd0, tx_ready_o}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid-tx reset");
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("post-reset rx empty", {31'd0, rx_valid_o}, 32'd0);
        chk("post-reset tx ready", {31'd0, tx_ready_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
